pingpong_frame_buf: RTL and testbench



---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_bank.sv | 38 +++
 rtl/pingpong_frame_buf.sv | 174 +++++++++++++++++
 tb/tb_pingpong_frame_buf.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the ping-pong frame buffer: default geometry,
// RGB channel bit offsets, controller state encoding and an index-width helper.
package fb_pkg;

    localparam int unsigned CH_W_DEF   = 8;
    localparam int unsigned DEPTH_DEF  = 10000;
    localparam int unsigned ADDR_W_DEF = 20;

    // Channel LSB positions inside a pixel word for the default channel width.
    localparam int unsigned R_LSB = 0;
    localparam int unsigned G_LSB = CH_W_DEF;
    localparam int unsigned B_LSB = 2 * CH_W_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    // Bits needed to index a bank of the given depth (at least one).
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: DEPTH x PIX_W storage, one write port, one registered read port.
// Ports:
//   clk           rising-edge clock
//   we/widx/wdata write strobe, index, pixel
//   re/ridx       read strobe, index
//   rdata         registered read data, holds when re is low
module fb_bank
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned PIX_W = 3 * CH_W_DEF,
    parameter int unsigned IDX_W = idx_w(DEPTH_DEF)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [PIX_W-1:0] wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] ridx,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rdata_q;

    // Storage is deliberately not reset; callers keep indices below DEPTH.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[ridx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pingpong_frame_buf.sv
// Double-buffered RGB pixel store. Writes go to the back bank, reads to the
// front bank; a swap request exchanges them. Read data is split into R/G/B
// with a valid strobe, and out-of-range accesses pulse rd_err/wr_err.
// Optional feature macro FB_CLEAR_ON_SWAP_EN: every swap zeroes the new back
// bank, one address per cycle, while busy is high.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   we, waddr, wdata      back-bank write
//   re, raddr             front-bank read
//   swap_req              exchange banks
//   R, G, B, rd_valid     registered read channels and strobe
//   swap_ack, front_sel   swap taken pulse, bank currently read
//   rd_err, wr_err        access dropped pulses
//   busy                  clear engine active
module pingpong_frame_buf
    import fb_pkg::*;
#(
    parameter int unsigned CH_W   = CH_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [3*CH_W-1:0]   wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic                swap_req,
    output logic [CH_W-1:0]     R,
    output logic [CH_W-1:0]     G,
    output logic [CH_W-1:0]     B,
    output logic                rd_valid,
    output logic                swap_ack,
    output logic                front_sel,
    output logic                rd_err,
    output logic                wr_err,
    output logic                busy
);

    localparam int unsigned PIX_W = 3 * CH_W;
    localparam int unsigned IDX_W = idx_w(DEPTH);
    localparam int unsigned R_OFS = (R_LSB / CH_W_DEF) * CH_W;
    localparam int unsigned G_OFS = (G_LSB / CH_W_DEF) * CH_W;
    localparam int unsigned B_OFS = (B_LSB / CH_W_DEF) * CH_W;

    fb_state_t state_q, state_d;
    logic front_sel_q, front_sel_d;
    logic swap_ack_q, swap_ack_d;
    logic wr_err_q, wr_err_d;
    logic rd_err_q, rd_err_d;
    logic rd_valid_q, rd_valid_d;
    logic rzero_q, rzero_d;    // last read was out of range (or reset): show zeros
    logic rsel_q, rsel_d;      // bank that produced the held read data
    logic busy_q, busy_d;
`ifdef FB_CLEAR_ON_SWAP_EN
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
`endif

    logic             wr_oor_c, rd_oor_c, swap_ok_c, wr_ok_c, rd_ok_c;
    logic             bank_we_c;
    logic [IDX_W-1:0] bank_widx_c;
    logic [PIX_W-1:0] bank_wdata_c;
    logic [PIX_W-1:0] rdata0_c, rdata1_c, pix_c;

    // Next-state and bank control.
    always_comb begin
        state_d      = state_q;
        wr_oor_c     = {1'b0, waddr} >= (ADDR_W+1)'(DEPTH);
        rd_oor_c     = {1'b0, raddr} >= (ADDR_W+1)'(DEPTH);
        swap_ok_c    = swap_req && (state_q == IDLE);
        wr_ok_c      = we && !wr_oor_c && (state_q == IDLE);
        rd_ok_c      = re && !rd_oor_c;
        front_sel_d  = front_sel_q ^ swap_ok_c;
        swap_ack_d   = swap_ok_c;
        wr_err_d     = we && !wr_ok_c;
        rd_valid_d   = re;
        rd_err_d     = re && rd_oor_c;
        rzero_d      = re ? rd_oor_c : rzero_q;
        rsel_d       = re ? front_sel_q : rsel_q;
        bank_we_c    = wr_ok_c;
        bank_widx_c  = IDX_W'(waddr);
        bank_wdata_c = wdata;
`ifdef FB_CLEAR_ON_SWAP_EN
        clr_idx_d = clr_idx_q;
        case (state_q)
            IDLE: begin
                if (swap_ok_c) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                // front_sel_q already points at the new front, so the back is the cleared bank.
                bank_we_c    = 1'b1;
                bank_widx_c  = clr_idx_q;
                bank_wdata_c = '0;
                clr_idx_d    = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`else
        state_d = IDLE;
`endif
        busy_d = (state_d == CLEAR);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rzero_q     <= 1'b1;
            rsel_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
            clr_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_ack_q  <= swap_ack_d;
            wr_err_q    <= wr_err_d;
            rd_err_q    <= rd_err_d;
            rd_valid_q  <= rd_valid_d;
            rzero_q     <= rzero_d;
            rsel_q      <= rsel_d;
            busy_q      <= busy_d;
`ifdef FB_CLEAR_ON_SWAP_EN
            clr_idx_q   <= clr_idx_d;
`endif
        end
    end

    // Writes land in the back bank, reads come from the front bank (pre-swap select).
    fb_bank #(.DEPTH(DEPTH), .PIX_W(PIX_W), .IDX_W(IDX_W)) u_bank0 (
        .clk   (clk),
        .we    (bank_we_c && front_sel_q && !reset),
        .widx  (bank_widx_c),
        .wdata (bank_wdata_c),
        .re    (rd_ok_c && !front_sel_q),
        .ridx  (IDX_W'(raddr)),
        .rdata (rdata0_c)
    );

    fb_bank #(.DEPTH(DEPTH), .PIX_W(PIX_W), .IDX_W(IDX_W)) u_bank1 (
        .clk   (clk),
        .we    (bank_we_c && !front_sel_q && !reset),
        .widx  (bank_widx_c),
        .wdata (bank_wdata_c),
        .re    (rd_ok_c && front_sel_q),
        .ridx  (IDX_W'(raddr)),
        .rdata (rdata1_c)
    );

    assign pix_c     = rzero_q ? '0 : (rsel_q ? rdata1_c : rdata0_c);
    assign R         = pix_c[R_OFS +: CH_W];
    assign G         = pix_c[G_OFS +: CH_W];
    assign B         = pix_c[B_OFS +: CH_W];
    assign rd_valid  = rd_valid_q;
    assign swap_ack  = swap_ack_q;
    assign front_sel = front_sel_q;
    assign rd_err    = rd_err_q;
    assign wr_err    = wr_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pingpong_frame_buf.sv
// Directed bench for pingpong_frame_buf: a per-cycle vector table for the
// default build, plus hand-written reset and clear-engine sequences.
module tb_pingpong_frame_buf;
    import fb_pkg::*;

    localparam int unsigned CH_W   = 8;
    localparam int unsigned ADDR_W = 20;
`ifdef FB_CLEAR_ON_SWAP_EN
    localparam int unsigned DEPTH  = 16;
`else
    localparam int unsigned DEPTH  = 10000;
`endif

    logic              clk, reset, we, re, swap_req;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [23:0]       wdata;
    logic [CH_W-1:0]   R, G, B;
    logic              rd_valid, swap_ack, front_sel, rd_err, wr_err, busy;

    int total = 0;
    int bad   = 0;

    pingpong_frame_buf #(.CH_W(CH_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .swap_req(swap_req),
        .R(R), .G(G), .B(B), .rd_valid(rd_valid), .swap_ack(swap_ack),
        .front_sel(front_sel), .rd_err(rd_err), .wr_err(wr_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        int unsigned waddr;
        logic [23:0] wdata;
        logic        re;
        int unsigned raddr;
        logic        swap;
        logic        chk_pix;
        logic [23:0] exp_pix;
        logic        exp_valid;
        logic        exp_rerr;
        logic        exp_werr;
        logic        exp_ack;
        logic        exp_front;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic w, input int unsigned wa,
                                input logic [23:0] wd, input logic r, input int unsigned ra,
                                input logic s, input logic cp, input logic [23:0] ep,
                                input logic ev, input logic er, input logic ew,
                                input logic ea, input logic ef);
        vec_t v;
        v.name = n; v.we = w; v.waddr = wa; v.wdata = wd; v.re = r; v.raddr = ra;
        v.swap = s; v.chk_pix = cp; v.exp_pix = ep; v.exp_valid = ev; v.exp_rerr = er;
        v.exp_werr = ew; v.exp_ack = ea; v.exp_front = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, then settle past the edge.
    task automatic step(input logic i_we, input int unsigned i_waddr, input logic [23:0] i_wdata,
                        input logic i_re, input int unsigned i_raddr, input logic i_swap);
        we = i_we; waddr = ADDR_W'(i_waddr); wdata = i_wdata;
        re = i_re; raddr = ADDR_W'(i_raddr); swap_req = i_swap;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 24'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pix"},   {8'h0, B, G, R}, 32'h0);
        chk({tag, " valid"}, 32'(rd_valid), 32'h0);
        chk({tag, " ack"},   32'(swap_ack), 32'h0);
        chk({tag, " front"}, 32'(front_sel), 32'h0);
        chk({tag, " rerr"},  32'(rd_err), 32'h0);
        chk({tag, " werr"},  32'(wr_err), 32'h0);
        chk({tag, " busy"},  32'(busy), 32'h0);
    endtask

`ifdef FB_CLEAR_ON_SWAP_EN
    // Count busy cycles until busy drops; cnt already holds cycles seen so far.
    task automatic finish_clear(inout int cnt);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            idle();
            if (busy) cnt++;
        end
    endtask
`endif

    initial begin
        vec_t v;
        int   n;
        reset = 1'b1; we = 1'b0; re = 1'b0; swap_req = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;
        idle();
        idle();
        chk_reset_vals("reset");
        reset = 1'b0;

`ifndef FB_CLEAR_ON_SWAP_EN
        // name, we, waddr, wdata, re, raddr, swap, chk_pix, pix, valid, rerr, werr, ack, front
        vecs.push_back(mk("wr0",      1, 0,     24'h010203, 0, 0,     0, 1, 24'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("wr1",      1, 1,     24'h040506, 0, 0,     0, 1, 24'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("wr2",      1, 2,     24'h070809, 0, 0,     0, 1, 24'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("wr3",      1, 3,     24'h0A0B0C, 0, 0,     0, 1, 24'h0,      0, 0, 0, 0, 0));
        vecs.push_back(mk("wr5_rd5",  1, 5,     24'hAABBCC, 1, 5,     0, 0, 24'h0,      1, 0, 0, 0, 0));
        vecs.push_back(mk("swap1",    0, 0,     24'h0,      0, 0,     1, 0, 24'h0,      0, 0, 0, 1, 1));
        vecs.push_back(mk("rd5",      0, 0,     24'h0,      1, 5,     0, 1, 24'hAABBCC, 1, 0, 0, 0, 1));
        vecs.push_back(mk("hold",     0, 0,     24'h0,      0, 0,     0, 1, 24'hAABBCC, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rd0",      0, 0,     24'h0,      1, 0,     0, 1, 24'h010203, 1, 0, 0, 0, 1));
        vecs.push_back(mk("rd1",      0, 0,     24'h0,      1, 1,     0, 1, 24'h040506, 1, 0, 0, 0, 1));
        vecs.push_back(mk("rd2",      0, 0,     24'h0,      1, 2,     0, 1, 24'h070809, 1, 0, 0, 0, 1));
        vecs.push_back(mk("rd3",      0, 0,     24'h0,      1, 3,     0, 1, 24'h0A0B0C, 1, 0, 0, 0, 1));
        vecs.push_back(mk("wr_last",  1, 9999,  24'h5A5A5A, 1, 10000, 0, 1, 24'h0,      1, 1, 0, 0, 1));
        vecs.push_back(mk("oor_hold", 0, 0,     24'h0,      0, 0,     0, 1, 24'h0,      0, 0, 0, 0, 1));
        vecs.push_back(mk("wr_oor",   1, 10000, 24'hFFFFFF, 0, 0,     0, 1, 24'h0,      0, 0, 1, 0, 1));
        vecs.push_back(mk("wr_max",   1, 20'hFFFFF, 24'hFFFFFF, 0, 0, 0, 1, 24'h0,      0, 0, 1, 0, 1));
        vecs.push_back(mk("werr_off", 0, 0,     24'h0,      0, 0,     0, 1, 24'h0,      0, 0, 0, 0, 1));
        vecs.push_back(mk("wr_swap",  1, 3,     24'h123456, 0, 0,     1, 1, 24'h0,      0, 0, 0, 1, 0));
        vecs.push_back(mk("rd3_new",  0, 0,     24'h0,      1, 3,     0, 1, 24'h123456, 1, 0, 0, 0, 0));
        vecs.push_back(mk("rd_last",  0, 0,     24'h0,      1, 9999,  0, 1, 24'h5A5A5A, 1, 0, 0, 0, 0));
        vecs.push_back(mk("rd_swap",  0, 0,     24'h0,      1, 3,     1, 1, 24'h123456, 1, 0, 0, 1, 1));
        vecs.push_back(mk("rd3_b1",   0, 0,     24'h0,      1, 3,     0, 1, 24'h0A0B0C, 1, 0, 0, 0, 1));
        vecs.push_back(mk("swap_h1",  0, 0,     24'h0,      0, 0,     1, 1, 24'h0A0B0C, 0, 0, 0, 1, 0));
        vecs.push_back(mk("swap_h2",  0, 0,     24'h0,      0, 0,     1, 1, 24'h0A0B0C, 0, 0, 0, 1, 1));
        vecs.push_back(mk("swap_off", 0, 0,     24'h0,      0, 0,     0, 1, 24'h0A0B0C, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rw_same",  1, 0,     24'h999999, 1, 0,     0, 1, 24'h010203, 1, 0, 0, 0, 1));
        vecs.push_back(mk("swap_b0",  0, 0,     24'h0,      0, 0,     1, 1, 24'h010203, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rd0_new",  0, 0,     24'h0,      1, 0,     0, 1, 24'h999999, 1, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.we, v.waddr, v.wdata, v.re, v.raddr, v.swap);
            if (v.chk_pix) chk({v.name, " pix"}, {8'h0, B, G, R}, 32'(v.exp_pix));
            chk({v.name, " valid"}, 32'(rd_valid), 32'(v.exp_valid));
            chk({v.name, " rerr"},  32'(rd_err),   32'(v.exp_rerr));
            chk({v.name, " werr"},  32'(wr_err),   32'(v.exp_werr));
            chk({v.name, " ack"},   32'(swap_ack), 32'(v.exp_ack));
            chk({v.name, " front"}, 32'(front_sel), 32'(v.exp_front));
            chk({v.name, " busy"},  32'(busy),     32'h0);
        end

        // Reset with a read pending and the front on bank1.
        step(1'b0, 0, 24'h0, 1'b0, 0, 1'b1);
        chk("pre_rst front", 32'(front_sel), 32'h1);
        reset = 1'b1;
        step(1'b1, 20'hFFFFF, 24'h0, 1'b1, 0, 1'b0);
        chk_reset_vals("rst_rd");
        reset = 1'b0;
        idle();
        chk_reset_vals("post_rst");
`else
        // Preload bank1 while bank0 is front, then swap and time the clear.
        step(1'b1, 2, 24'h112233, 1'b0, 0, 1'b0);
        chk("pre wr werr", 32'(wr_err), 32'h0);
        step(1'b0, 0, 24'h0, 1'b0, 0, 1'b1);
        chk("c1 ack", 32'(swap_ack), 32'h1);
        chk("c1 front", 32'(front_sel), 32'h1);
        chk("c1 busy", 32'(busy), 32'h1);
        n = 1;
        step(1'b1, 4, 24'h555555, 1'b0, 0, 1'b0);
        if (busy) n++;
        chk("c1 wr werr", 32'(wr_err), 32'h1);
        step(1'b0, 0, 24'h0, 1'b0, 0, 1'b1);
        if (busy) n++;
        chk("c1 swap ack", 32'(swap_ack), 32'h0);
        chk("c1 swap front", 32'(front_sel), 32'h1);
        step(1'b0, 0, 24'h0, 1'b1, 2, 1'b0);
        if (busy) n++;
        chk("c1 rd pix", {8'h0, B, G, R}, 32'h112233);
        chk("c1 rd valid", 32'(rd_valid), 32'h1);
        finish_clear(n);
        chk("c1 busy cycles", 32'(n), 32'(DEPTH));

        // Fill cleared bank0, swap it to front (clears bank1), read it back.
        step(1'b1, 4, 24'hABCDEF, 1'b0, 0, 1'b0);
        chk("c2 wr werr", 32'(wr_err), 32'h0);
        step(1'b0, 0, 24'h0, 1'b0, 0, 1'b1);
        chk("c2 front", 32'(front_sel), 32'h0);
        n = busy ? 1 : 0;
        finish_clear(n);
        chk("c2 busy cycles", 32'(n), 32'(DEPTH));
        step(1'b0, 0, 24'h0, 1'b1, 4, 1'b0);
        chk("c2 rd pix", {8'h0, B, G, R}, 32'hABCDEF);

        // Bank1 was zeroed by the last clear.
        step(1'b0, 0, 24'h0, 1'b0, 0, 1'b1);
        chk("c3 ack", 32'(swap_ack), 32'h1);
        n = busy ? 1 : 0;
        finish_clear(n);
        chk("c3 busy cycles", 32'(n), 32'(DEPTH));
        step(1'b0, 0, 24'h0, 1'b1, 2, 1'b0);
        chk("c3 rd pix", {8'h0, B, G, R}, 32'h0);
        chk("c3 rd valid", 32'(rd_valid), 32'h1);

        // Reset in the middle of a clear with a read pending.
        step(1'b0, 0, 24'h0, 1'b0, 0, 1'b1);
        idle();
        idle();
        chk("mid busy", 32'(busy), 32'h1);
        reset = 1'b1;
        step(1'b0, 0, 24'h0, 1'b1, 4, 1'b0);
        chk_reset_vals("rst_clr");
        reset = 1'b0;
        idle();
        chk_reset_vals("post_rst");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
